// File: rtl/softmax_r2b_converter_pkg.sv
// Shared constants for the softmax row-to-block converter.
// FRAC_WIDTH describes the fixed-point format only; no arithmetic uses it.
package softmax_r2b_converter_pkg;

    localparam int WIDTH_SOFTMAX          = 16;
    localparam int FRAC_WIDTH_SOFTMAX     = 8;
    localparam int BLOCK_SIZE_SOFTMAX     = 2;
    localparam int TILE_SIZE_SOFTMAX      = 8;
    localparam int TOTAL_ELEMENTS_SOFTMAX = 64;

    localparam int R2B_BLOCKS_PER_TILE = TILE_SIZE_SOFTMAX / BLOCK_SIZE_SOFTMAX;
    localparam int R2B_TILES_PER_ROW   = TOTAL_ELEMENTS_SOFTMAX / TILE_SIZE_SOFTMAX;

    typedef logic r2b_state_t;
    localparam r2b_state_t R2B_IDLE = 1'b0;
    localparam r2b_state_t R2B_EMIT = 1'b1;

    // Counter width that never collapses to zero bits.
    function automatic int r2b_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/softmax_r2b_converter_tile_bank.sv
// One BLOCK_SIZE x TILE_SIZE storage bank: each row is written by its own lane,
// and one BLOCK_SIZE-wide column group is selected for the block output.
module softmax_r2b_converter_tile_bank
    import softmax_r2b_converter_pkg::*;
#(
    parameter int WIDTH      = WIDTH_SOFTMAX,
    parameter int BLOCK_SIZE = BLOCK_SIZE_SOFTMAX,
    parameter int TILE_SIZE  = TILE_SIZE_SOFTMAX,
    parameter int SEL_W      = r2b_bits(TILE_SIZE / BLOCK_SIZE)
) (
    input  logic                                i_clk,
    input  logic [BLOCK_SIZE-1:0]               i_we,
    input  logic [BLOCK_SIZE*TILE_SIZE*WIDTH-1:0] i_tile,
    input  logic [SEL_W-1:0]                    i_col_sel,
    output logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] o_block
);

    localparam int TILE_W = TILE_SIZE * WIDTH;

    logic [TILE_W-1:0] r_row [BLOCK_SIZE];

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < BLOCK_SIZE; r++) begin
            if (i_we[r]) begin
                r_row[r] <= i_tile[r*TILE_W +: TILE_W];
            end
        end
    end

    always_comb begin
        o_block = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                o_block[(i*BLOCK_SIZE+j)*WIDTH +: WIDTH] =
                    r_row[i][(int'(i_col_sel)*BLOCK_SIZE + j)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/softmax_r2b_converter.sv
// Ping-pong row-to-block converter: lanes fill one bank while the other drains
// as BLOCK_SIZE x BLOCK_SIZE blocks, tagged with their column index in the band.
module softmax_r2b_converter
    import softmax_r2b_converter_pkg::*;
#(
    parameter int WIDTH          = WIDTH_SOFTMAX,
    parameter int BLOCK_SIZE     = BLOCK_SIZE_SOFTMAX,
    parameter int TILE_SIZE      = TILE_SIZE_SOFTMAX,
    parameter int TOTAL_ELEMENTS = TOTAL_ELEMENTS_SOFTMAX
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [BLOCK_SIZE-1:0]                 i_in_valid,
    output logic [BLOCK_SIZE-1:0]                 o_in_ready,
    input  logic [BLOCK_SIZE*TILE_SIZE*WIDTH-1:0] i_in_tile,
    output logic                                  o_out_valid,
    input  logic                                  i_out_ready,
    output logic [BLOCK_SIZE*BLOCK_SIZE*WIDTH-1:0] o_out_block,
    output logic [$clog2(TOTAL_ELEMENTS/BLOCK_SIZE)-1:0] o_out_col_idx,
    output logic                                  o_out_last
);

    localparam int BPT    = TILE_SIZE / BLOCK_SIZE;
    localparam int TPR    = TOTAL_ELEMENTS / TILE_SIZE;
    localparam int BW     = r2b_bits(BPT);
    localparam int TW     = r2b_bits(TPR);
    localparam int IDX_W  = $clog2(TOTAL_ELEMENTS / BLOCK_SIZE);
    localparam int TILE_W = TILE_SIZE * WIDTH;
    localparam int BLK_W  = BLOCK_SIZE * BLOCK_SIZE * WIDTH;

    logic [BLOCK_SIZE-1:0] r_got;
    logic [1:0]            r_full;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    r2b_state_t            r_state;
    logic [BW-1:0]         r_b;
    logic [TW-1:0]         r_tile_cnt;
    logic [BLK_W-1:0]      r_out_block;

    logic [BLOCK_SIZE-1:0] w_accept;
    logic                  w_complete;
    logic                  w_hs;
    logic                  w_last_b;
    logic                  w_other;
    logic                  w_other_full;
    logic [BW-1:0]         w_rd_sel;
    logic [BLOCK_SIZE-1:0] w_bank_we    [2];
    logic [BW-1:0]         w_col_sel    [2];
    logic [BLK_W-1:0]      w_bank_block [2];
    logic [BLK_W-1:0]      w_next_first;

    assign o_in_ready   = ~r_got & {BLOCK_SIZE{~r_full[r_wr_bank]}};
    assign w_accept     = i_in_valid & o_in_ready;
    assign w_complete   = (&(r_got | w_accept)) && !r_full[r_wr_bank];
    assign w_hs         = (r_state == R2B_EMIT) && i_out_ready;
    assign w_last_b     = (r_b == BW'(BPT - 1));
    assign w_other      = ~r_rd_bank;
    // The other bank counts as ready even if its last lane lands this very edge.
    assign w_other_full = r_full[w_other] || (w_complete && (r_wr_bank == w_other));
    assign w_rd_sel     = (r_state == R2B_EMIT) ? r_b + BW'(1) : '0;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_bank_we[k] = (r_wr_bank == 1'(k)) ? w_accept : '0;
            w_col_sel[k] = (r_rd_bank == 1'(k)) ? w_rd_sel : '0;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_bank
        softmax_r2b_converter_tile_bank #(
            .WIDTH      (WIDTH),
            .BLOCK_SIZE (BLOCK_SIZE),
            .TILE_SIZE  (TILE_SIZE),
            .SEL_W      (BW)
        ) u_bank (
            .i_clk     (i_clk),
            .i_we      (w_bank_we[k]),
            .i_tile    (i_in_tile),
            .i_col_sel (w_col_sel[k]),
            .o_block   (w_bank_block[k])
        );
    end

    // First block of the next bank, bypassing lanes whose data is written this edge.
    always_comb begin
        w_next_first = w_bank_block[w_other];
        if (r_wr_bank == w_other) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (w_accept[i]) begin
                    for (int j = 0; j < BLOCK_SIZE; j++) begin
                        w_next_first[(i*BLOCK_SIZE+j)*WIDTH +: WIDTH] =
                            i_in_tile[i*TILE_W + j*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_got       <= '0;
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_state     <= R2B_IDLE;
            r_b         <= '0;
            r_tile_cnt  <= '0;
            r_out_block <= '0;
        end else begin
            if (w_complete) begin
                r_full[r_wr_bank] <= 1'b1;
                r_got             <= '0;
                r_wr_bank         <= ~r_wr_bank;
            end else begin
                r_got <= r_got | w_accept;
            end

            case (r_state)
                R2B_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state     <= R2B_EMIT;
                        r_b         <= '0;
                        r_out_block <= w_bank_block[r_rd_bank];
                    end
                end
                default: begin
                    if (w_hs) begin
                        if (w_last_b) begin
                            r_full[r_rd_bank] <= 1'b0;
                            r_rd_bank         <= ~r_rd_bank;
                            r_b               <= '0;
                            r_tile_cnt        <= (r_tile_cnt == TW'(TPR - 1)) ? '0
                                                 : r_tile_cnt + TW'(1);
                            if (w_other_full) begin
                                r_out_block <= w_next_first;
                            end else begin
                                r_state <= R2B_IDLE;
                            end
                        end else begin
                            r_b         <= r_b + BW'(1);
                            r_out_block <= w_bank_block[r_rd_bank];
                        end
                    end
                end
            endcase
        end
    end

    assign o_out_valid   = (r_state == R2B_EMIT);
    assign o_out_block   = r_out_block;
    assign o_out_col_idx = IDX_W'(r_tile_cnt) * IDX_W'(BPT) + IDX_W'(r_b);
    assign o_out_last    = o_out_valid && (o_out_col_idx == IDX_W'(TOTAL_ELEMENTS/BLOCK_SIZE - 1));

endmodule

// File: tb/tb_softmax_r2b_converter.sv
// Bench for softmax_r2b_converter: a tile-queue model predicts in_ready, out_valid,
// block contents, column index and out_last every cycle.
module tb_softmax_r2b_converter;
    import softmax_r2b_converter_pkg::*;

    localparam int W      = 16;
    localparam int BS     = 2;
    localparam int TS     = 8;
    localparam int TOT    = 64;
    localparam int BPT    = TS / BS;
    localparam int TPR    = TOT / TS;
    localparam int TILE_W = TS * W;
    localparam int BLK_W  = BS * BS * W;
    localparam int IDX_W  = $clog2(TOT / BS);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BS-1:0]     in_valid = '0;
    logic [BS-1:0]     in_ready;
    logic [BS*TILE_W-1:0] in_tile = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BLK_W-1:0]  out_block;
    logic [IDX_W-1:0]  out_col_idx;
    logic              out_last;

    always #5 clk = ~clk;

    softmax_r2b_converter #(
        .WIDTH(W), .BLOCK_SIZE(BS), .TILE_SIZE(TS), .TOTAL_ELEMENTS(TOT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_tile     (in_tile),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_block   (out_block),
        .o_out_col_idx (out_col_idx),
        .o_out_last    (out_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [TILE_W-1:0] m_q [BS][$];
    int  m_acc [BS];
    int  m_done, m_drained, m_b, m_edge, m_drain_edge;
    int  m_cedge [$];
    int  m_blocks, m_lasts;
    bit  m_live = 1'b0;
    logic [BS-1:0] m_rdy;
    bit  m_v;
    int  m_min;

    function automatic logic [BS-1:0] exp_ready();
        logic [BS-1:0] v;
        for (int r = 0; r < BS; r++)
            v[r] = (m_acc[r] == m_done) && (m_done - m_drained < 2);
        return v;
    endfunction

    function automatic bit exp_valid();
        if (m_done <= m_drained) return 1'b0;
        return (m_cedge[0] < m_edge) || (m_drain_edge == m_edge);
    endfunction

    function automatic logic [BLK_W-1:0] exp_block();
        logic [BLK_W-1:0]  v;
        logic [TILE_W-1:0] t;
        v = '0;
        for (int i = 0; i < BS; i++) begin
            t = m_q[i][0];
            for (int j = 0; j < BS; j++)
                v[(i*BS+j)*W +: W] = t[(m_b*BS+j)*W +: W];
        end
        return v;
    endfunction

    function automatic int exp_idx();
        return (m_drained % TPR) * BPT + m_b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < BS; r++) begin
                m_q[r].delete();
                m_acc[r] = 0;
            end
            m_cedge.delete();
            m_done = 0; m_drained = 0; m_b = 0; m_edge = 0; m_drain_edge = -1;
            m_live = 1'b1;
        end else if (m_live) begin
            m_rdy = exp_ready();
            m_v   = exp_valid();
            m_edge++;
            for (int r = 0; r < BS; r++) begin
                if (in_valid[r] && m_rdy[r]) begin
                    m_q[r].push_back(in_tile[r*TILE_W +: TILE_W]);
                    m_acc[r]++;
                end
            end
            if (m_v && out_ready) begin
                m_blocks++;
                if (exp_idx() == TOT/BS - 1) m_lasts++;
                m_b++;
                if (m_b == BPT) begin
                    m_b = 0;
                    for (int r = 0; r < BS; r++) void'(m_q[r].pop_front());
                    void'(m_cedge.pop_front());
                    m_drained++;
                    m_drain_edge = m_edge;
                end
            end
            m_min = m_acc[0];
            for (int r = 1; r < BS; r++) if (m_acc[r] < m_min) m_min = m_acc[r];
            while (m_done < m_min) begin
                m_done++;
                m_cedge.push_back(m_edge);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", BLK_W'(in_ready), BLK_W'(exp_ready()));
            chk("out_valid", BLK_W'(out_valid), BLK_W'(exp_valid()));
            if (exp_valid()) begin
                chk("out_block", out_block, exp_block());
                chk("out_col_idx", BLK_W'(out_col_idx), BLK_W'(exp_idx()));
                chk("out_last", BLK_W'(out_last), BLK_W'(exp_idx() == TOT/BS - 1));
            end else begin
                chk("out_last_idle", BLK_W'(out_last), '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [TILE_W-1:0] s_q [BS][$];
    int  s_delay [BS];
    bit  s_hold [BS];
    int  s_offer_pct = 100;
    bit  s_ready = 1'b1;
    bit  s_rand_ready = 1'b0;

    function automatic logic [TILE_W-1:0] tile_val(input int r, input int t);
        logic [TILE_W-1:0] v;
        for (int e = 0; e < TS; e++) v[e*W +: W] = 16'(r*256 + ((t*TS + e) % TOT));
        return v;
    endfunction

    task automatic load(input int r, input int t0, input int n);
        for (int t = t0; t < t0 + n; t++) s_q[r].push_back(tile_val(r, t));
    endtask

    task automatic drive();
        for (int r = 0; r < BS; r++) begin
            if (!s_hold[r] && s_q[r].size() > 0 && s_delay[r] == 0 &&
                ($urandom_range(99) < s_offer_pct)) begin
                in_valid[r] = 1'b1;
                in_tile[r*TILE_W +: TILE_W] = s_q[r][0];
                if (in_ready[r]) void'(s_q[r].pop_front());
            end else begin
                in_valid[r] = 1'b0;
                if (s_delay[r] > 0) s_delay[r]--;
            end
        end
        out_ready = s_rand_ready ? ($urandom_range(99) < 60) : s_ready;
    endtask

    task automatic step();
        @(negedge clk);
        drive();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_src();
        for (int r = 0; r < BS; r++) begin
            s_q[r].delete();
            s_delay[r] = 0;
            s_hold[r]  = 1'b0;
        end
        in_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_src();
        step();
        rst = 1'b0;
    endtask

    // Steps until out_valid; returns the number of steps taken (or -1 on timeout).
    task automatic wait_valid(input string name, output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk({name, "_timeout"}, '0, 1);
    endtask

    int lat;
    int found;
    int nb0;
    logic [BLK_W-1:0] held_block;

    initial begin
        m_blocks = 0;
        m_lasts  = 0;
        clear_src();

        // reset values
        do_reset();
        chk("rst_in_ready", BLK_W'(in_ready), BLK_W'(2'b11));
        chk("rst_out_valid", BLK_W'(out_valid), '0);
        chk("rst_col_idx", BLK_W'(out_col_idx), '0);
        chk("rst_block", out_block, '0);
        chk("rst_last", BLK_W'(out_last), '0);

        // both lanes together
        s_ready = 1'b1;
        load(0, 0, 1); load(1, 0, 1);
        step();
        wait_valid("t1", lat);
        chk("t1_latency", BLK_W'(lat), BLK_W'(2));
        chk("t1_block0", out_block, 64'h0101_0100_0001_0000);
        chk("t1_idx0", BLK_W'(out_col_idx), '0);
        run(6);

        // lane1 five cycles behind lane0
        load(0, 1, 1); load(1, 1, 1);
        s_delay[1] = 5;
        step(); step(); step();
        chk("t2_lane0_blocked", BLK_W'(in_ready), BLK_W'(2'b10));
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (in_valid[1]) begin found = 1; break; end
        end
        chk("t2_lane1_offered", BLK_W'(found), 1);
        wait_valid("t2", lat);
        chk("t2_latency", BLK_W'(lat), BLK_W'(2));
        chk("t2_block", out_block, 64'h0109_0108_0009_0008);
        chk("t2_idx", BLK_W'(out_col_idx), BLK_W'(4));
        run(6);

        // consumer stalled, three tiles per lane
        s_ready = 1'b0;
        load(0, 2, 3); load(1, 2, 3);
        run(12);
        chk("t3_in_ready_stall", BLK_W'(in_ready), '0);
        chk("t3_valid", BLK_W'(out_valid), 1);
        chk("t3_block", out_block, 64'h0111_0110_0011_0010);
        chk("t3_third_pending", BLK_W'(s_q[0].size() + s_q[1].size()), BLK_W'(2));
        held_block = out_block;
        run(3);
        chk("t3_block_held", out_block, held_block);
        chk("t3_idx_held", BLK_W'(out_col_idx), BLK_W'(8));
        s_ready = 1'b1;
        run(30);

        // full band, random backpressure and gaps
        do_reset();
        s_rand_ready = 1'b1;
        s_offer_pct  = 70;
        load(0, 0, 8); load(1, 0, 8);
        nb0 = m_blocks;
        m_lasts = 0;
        for (int k = 0; k < 600 && (m_blocks - nb0) < 32; k++) step();
        chk("t4_blocks", BLK_W'(m_blocks - nb0), BLK_W'(32));
        chk("t4_lasts", BLK_W'(m_lasts), 1);
        s_rand_ready = 1'b0;
        s_offer_pct  = 100;
        run(4);
        load(0, 0, 1); load(1, 0, 1);
        wait_valid("t4_next", lat);
        chk("t4_next_band_idx", BLK_W'(out_col_idx), '0);
        run(8);

        // lane1 completes bank1 on the same edge bank0 drains its last block
        do_reset();
        s_ready = 1'b1;
        load(0, 0, 2); load(1, 0, 1);
        step();
        load(1, 1, 1);
        s_hold[1] = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid && out_col_idx == 3) begin found = 1; break; end
        end
        chk("t5_reached_idx3", BLK_W'(found), 1);
        s_hold[1] = 1'b0;
        drive();
        for (int k = 0; k < BPT; k++) begin
            step();
            chk("t5_no_bubble", BLK_W'(out_valid), 1);
            chk("t5_idx", BLK_W'(out_col_idx), BLK_W'(4 + k));
        end
        chk("t5_second_block", out_block, 64'h010f_010e_000f_000e);
        run(4);

        // reset in the middle of a band
        do_reset();
        s_ready = 1'b1;
        load(0, 0, 2); load(1, 0, 2);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid && out_col_idx == 2) begin found = 1; break; end
        end
        chk("t6_reached_idx2", BLK_W'(found), 1);
        rst = 1'b1;
        clear_src();
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        chk("t6_valid", BLK_W'(out_valid), '0);
        chk("t6_in_ready", BLK_W'(in_ready), BLK_W'(2'b11));
        chk("t6_idx", BLK_W'(out_col_idx), '0);
        chk("t6_last", BLK_W'(out_last), '0);
        load(0, 0, 1); load(1, 0, 1);
        wait_valid("t6", lat);
        chk("t6_restart_idx", BLK_W'(out_col_idx), '0);
        chk("t6_restart_block", out_block, 64'h0101_0100_0001_0000);
        run(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
